// File: rtl/config_frame_pkg.sv
// Shared encodings for the configuration frame loader: FSM states, command codes,
// sync word and header field positions.
package config_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_ERROR  = 2'd3
    } state_e;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned COUNT_W   = 16;
    localparam int unsigned CMD_MSB   = 31;
    localparam int unsigned CMD_LSB   = 24;
    localparam int unsigned ROW_MSB   = 23;
    localparam int unsigned ROW_LSB   = 16;
    localparam int unsigned COUNT_MSB = 15;
    localparam int unsigned COUNT_LSB = 0;

    localparam logic [7:0]        CMD_WRITE         = 8'h01;
    localparam logic [7:0]        CMD_END           = 8'h00;
    localparam logic [WORD_W-1:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

    // Cycles after an accepted word during which further strobes are dropped.
    localparam logic [1:0] GUARD_GAP = 2'd2;

endpackage

// File: rtl/config_frame_loader_strobe_gen.sv
// Spacing guard (accept/overrun) and the two-stage frame data/strobe output pipeline.
module config_frame_strobe_gen
    import config_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_strobe,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              fire,
    output logic              accept_c,
    output logic [WORD_W-1:0] frame_data,
    output logic              frame_strobe,
    output logic              overrun
);

    logic [1:0] guard;
    logic       fire_d;

    assign accept_c = wr_strobe && (guard == 2'd0);

    // Data lands one cycle after acceptance; the strobe follows one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard        <= 2'd0;
            overrun      <= 1'b0;
            fire_d       <= 1'b0;
            frame_strobe <= 1'b0;
            frame_data   <= '0;
        end else begin
            if (accept_c) begin
                guard <= GUARD_GAP;
            end else if (guard != 2'd0) begin
                guard <= guard - 2'd1;
            end
            if (wr_strobe && (guard != 2'd0)) begin
                overrun <= 1'b1;
            end
            fire_d       <= fire;
            frame_strobe <= fire_d;
            if (fire) begin
                frame_data <= wr_data;
            end
        end
    end

endmodule

// File: rtl/config_frame_loader.sv
// Parses the framed command stream (sync, headers, data) and drives fabric
// configuration frames with row select, plus status/error reporting.
module config_frame_loader
    import config_frame_pkg::*;
#(
    parameter int unsigned       NUM_ROWS      = 16,
    parameter int unsigned       ROW_SEL_WIDTH = $clog2(NUM_ROWS),
    parameter logic [WORD_W-1:0] SYNC_WORD     = DEFAULT_SYNC_WORD
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     word_write_strobe_i,
    input  logic [WORD_W-1:0]        write_data_i,
    output logic [WORD_W-1:0]        frame_data_o,
    output logic [ROW_SEL_WIDTH-1:0] row_select_o,
    output logic                     frame_strobe_o,
    output logic                     active_o,
    output logic                     config_done_o,
    output logic                     error_o,
    output logic                     overrun_o
);

    state_e               state;
    logic [COUNT_W-1:0]   frame_count;
    logic                 accept_c;
    logic                 fire_c;
    logic                 is_sync_c;
    logic                 row_ok_c;
    logic [7:0]           hdr_cmd;
    logic [7:0]           hdr_row;
    logic [COUNT_W-1:0]   hdr_count;

    assign hdr_cmd   = write_data_i[CMD_MSB:CMD_LSB];
    assign hdr_row   = write_data_i[ROW_MSB:ROW_LSB];
    assign hdr_count = write_data_i[COUNT_MSB:COUNT_LSB];
    assign is_sync_c = (write_data_i == SYNC_WORD);
    assign row_ok_c  = (32'(hdr_row) < NUM_ROWS);
    assign fire_c    = accept_c && (state == ST_DATA);

    config_frame_strobe_gen u_strobe_gen (
        .clk          (clk_i),
        .rst_n        (reset_n_i),
        .wr_strobe    (word_write_strobe_i),
        .wr_data      (write_data_i),
        .fire         (fire_c),
        .accept_c     (accept_c),
        .frame_data   (frame_data_o),
        .frame_strobe (frame_strobe_o),
        .overrun      (overrun_o)
    );

    // Command FSM with frame counter; status outputs are registered alongside state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= ST_IDLE;
            frame_count   <= '0;
            row_select_o  <= '0;
            active_o      <= 1'b0;
            config_done_o <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            config_done_o <= 1'b0;
            if (accept_c) begin
                unique case (state)
                    ST_IDLE: begin
                        if (is_sync_c) begin
                            state    <= ST_HEADER;
                            active_o <= 1'b1;
                        end
                    end
                    ST_HEADER: begin
                        if (is_sync_c) begin
                            state <= ST_HEADER;
                        end else if ((hdr_cmd == CMD_WRITE) && row_ok_c) begin
                            row_select_o <= hdr_row[ROW_SEL_WIDTH-1:0];
                            frame_count  <= hdr_count;
                            if (hdr_count != '0) begin
                                state <= ST_DATA;
                            end
                        end else if (hdr_cmd == CMD_END) begin
                            state         <= ST_IDLE;
                            active_o      <= 1'b0;
                            config_done_o <= 1'b1;
                        end else begin
                            state   <= ST_ERROR;
                            error_o <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        frame_count <= frame_count - COUNT_W'(1);
                        if (frame_count == COUNT_W'(1)) begin
                            state <= ST_HEADER;
                        end
                    end
                    ST_ERROR: begin
                        if (is_sync_c) begin
                            state <= ST_HEADER;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_config_frame_loader.sv
// Self-checking bench: cycle-stamped behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_config_frame_loader;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        word_write_strobe_i;
    logic [31:0] write_data_i;
    logic [31:0] frame_data_o;
    logic [3:0]  row_select_o;
    logic        frame_strobe_o;
    logic        active_o;
    logic        config_done_o;
    logic        error_o;
    logic        overrun_o;

    config_frame_loader dut (
        .clk_i               (clk_i),
        .reset_n_i           (reset_n_i),
        .word_write_strobe_i (word_write_strobe_i),
        .write_data_i        (write_data_i),
        .frame_data_o        (frame_data_o),
        .row_select_o        (row_select_o),
        .frame_strobe_o      (frame_strobe_o),
        .active_o            (active_o),
        .config_done_o       (config_done_o),
        .error_o             (error_o),
        .overrun_o           (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: mode 0=idle 1=header 2=data 3=error; outputs derived from cycle stamps.
    int          cyc        = 0;
    int          m_mode     = 0;
    int          m_last     = -100;
    int          m_rem      = 0;
    logic [3:0]  m_row      = '0;
    logic [31:0] m_fdata    = '0;
    int          m_strobe_at = -1;
    int          m_done_at  = -1;
    bit          m_err      = 1'b0;
    bit          m_ovr      = 1'b0;
    int          n_strobe   = 0;
    int          n_done     = 0;

    always @(negedge clk_i) begin
        logic [7:0]  cmd;
        logic [7:0]  row;
        logic [15:0] cnt;
        cyc++;
        if (!reset_n_i) begin
            chk("reset_frame_data", frame_data_o, 32'h0);
            chk("reset_strobe", 32'(frame_strobe_o), 32'h0);
            chk("reset_row", 32'(row_select_o), 32'h0);
            chk("reset_active", 32'(active_o), 32'h0);
            chk("reset_error", 32'(error_o), 32'h0);
            chk("reset_overrun", 32'(overrun_o), 32'h0);
            m_mode = 0; m_last = -100; m_rem = 0; m_row = '0; m_fdata = '0;
            m_strobe_at = -1; m_done_at = -1; m_err = 1'b0; m_ovr = 1'b0;
        end else begin
            chk("frame_data", frame_data_o, m_fdata);
            chk("row_select", 32'(row_select_o), 32'(m_row));
            chk("frame_strobe", 32'(frame_strobe_o), 32'(cyc == m_strobe_at));
            chk("config_done", 32'(config_done_o), 32'(cyc == m_done_at));
            chk("active", 32'(active_o), 32'(m_mode != 0));
            chk("error", 32'(error_o), 32'(m_err));
            chk("overrun", 32'(overrun_o), 32'(m_ovr));
            n_strobe += int'(frame_strobe_o);
            n_done   += int'(config_done_o);
            if (word_write_strobe_i) begin
                if (cyc - m_last < 3) begin
                    m_ovr = 1'b1;
                end else begin
                    m_last = cyc;
                    cmd = write_data_i[31:24];
                    row = write_data_i[23:16];
                    cnt = write_data_i[15:0];
                    case (m_mode)
                        0: if (write_data_i == SYNC) m_mode = 1;
                        1: begin
                            if (write_data_i == SYNC) begin
                                m_mode = 1;
                            end else if (cmd == 8'h01 && row < 8'd16) begin
                                m_row = row[3:0];
                                m_rem = int'(cnt);
                                if (m_rem > 0) m_mode = 2;
                            end else if (cmd == 8'h00) begin
                                m_done_at = cyc + 1;
                                m_mode = 0;
                            end else begin
                                m_err = 1'b1;
                                m_mode = 3;
                            end
                        end
                        2: begin
                            m_fdata = write_data_i;
                            m_strobe_at = cyc + 2;
                            m_rem--;
                            if (m_rem == 0) m_mode = 1;
                        end
                        default: if (write_data_i == SYNC) m_mode = 1;
                    endcase
                end
            end
        end
    end

    // All drivers start and end aligned to posedge+1.
    task automatic send(input logic [31:0] w, input int gap);
        word_write_strobe_i = 1'b1;
        write_data_i        = w;
        @(posedge clk_i); #1;
        word_write_strobe_i = 1'b0;
        repeat (gap - 1) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic do_reset();
        #1 reset_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
    endtask

    int s0;
    int d0;

    initial begin
        reset_n_i           = 1'b1;
        word_write_strobe_i = 1'b0;
        write_data_i        = '0;
        #2 reset_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        chk("init_active", 32'(active_o), 32'h0);
        chk("init_frame_data", frame_data_o, 32'h0);

        // Sync then a single frame with precise timing.
        s0 = n_strobe;
        send(SYNC, 4);
        send(32'h0103_0001, 4);
        word_write_strobe_i = 1'b1;
        write_data_i        = 32'hDEAD_BEEF;
        @(posedge clk_i); #1;
        word_write_strobe_i = 1'b0;
        chk("t1_data_at_t1", frame_data_o, 32'hDEAD_BEEF);
        chk("t1_no_strobe_t1", 32'(frame_strobe_o), 32'h0);
        @(posedge clk_i); #1;
        chk("t1_strobe_t2", 32'(frame_strobe_o), 32'h1);
        @(posedge clk_i); #1;
        chk("t1_no_strobe_t3", 32'(frame_strobe_o), 32'h0);
        @(posedge clk_i); #1;
        chk("t1_row", 32'(row_select_o), 32'h3);
        chk("t1_error", 32'(error_o), 32'h0);
        chk("t1_strobe_count", 32'(n_strobe - s0), 32'h1);

        // Burst of three frames then END.
        s0 = n_strobe; d0 = n_done;
        send(32'h0100_0003, 4);
        send(32'h1111_1111, 4);
        send(32'h2222_2222, 4);
        send(32'h3333_3333, 4);
        send(32'h0000_0000, 4);
        chk("burst_strobes", 32'(n_strobe - s0), 32'h3);
        chk("burst_done", 32'(n_done - d0), 32'h1);
        chk("burst_active", 32'(active_o), 32'h0);
        chk("burst_last_data", frame_data_o, 32'h3333_3333);

        // Illegal command.
        s0 = n_strobe;
        send(SYNC, 4);
        send(32'hAB00_0001, 4);
        chk("illegal_error", 32'(error_o), 32'h1);
        send(32'h1234_5678, 4);
        chk("illegal_no_strobe", 32'(n_strobe - s0), 32'h0);
        send(SYNC, 4);
        chk("illegal_resync_active", 32'(active_o), 32'h1);
        chk("illegal_error_sticky", 32'(error_o), 32'h1);

        // Row out of range.
        do_reset();
        s0 = n_strobe;
        send(SYNC, 4);
        send(32'h0110_0001, 4);
        send(32'h5555_5555, 4);
        chk("row_range_error", 32'(error_o), 32'h1);
        chk("row_range_no_strobe", 32'(n_strobe - s0), 32'h0);

        // Overrun: second data word one cycle later is dropped.
        do_reset();
        send(SYNC, 4);
        send(32'h0107_0002, 4);
        s0 = n_strobe; d0 = n_done;
        send(32'hAAAA_0001, 1);
        send(32'hBBBB_0002, 4);
        chk("ovr_flag", 32'(overrun_o), 32'h1);
        chk("ovr_data_kept", frame_data_o, 32'hAAAA_0001);
        chk("ovr_one_strobe", 32'(n_strobe - s0), 32'h1);
        send(32'hCCCC_0003, 4);
        chk("ovr_two_strobes", 32'(n_strobe - s0), 32'h2);
        send(32'h0000_0000, 4);
        chk("ovr_done", 32'(n_done - d0), 32'h1);
        chk("ovr_sticky", 32'(overrun_o), 32'h1);

        // Maximum count: sync word and END word are plain data inside DATA.
        do_reset();
        send(SYNC, 4);
        send(32'h0102_FFFF, 4);
        s0 = n_strobe; d0 = n_done;
        send(SYNC, 4);
        send(32'h0000_0000, 4);
        send(32'h7777_7777, 4);
        chk("max_strobes", 32'(n_strobe - s0), 32'h3);
        chk("max_no_done", 32'(n_done - d0), 32'h0);
        chk("max_active", 32'(active_o), 32'h1);
        chk("max_row", 32'(row_select_o), 32'h2);

        // Reset between a data accept and its strobe.
        do_reset();
        send(SYNC, 4);
        send(32'h0105_0001, 4);
        s0 = n_strobe;
        word_write_strobe_i = 1'b1;
        write_data_i        = 32'h9999_9999;
        @(posedge clk_i); #1;
        word_write_strobe_i = 1'b0;
        do_reset();
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        chk("midrst_no_strobe", 32'(n_strobe - s0), 32'h0);
        chk("midrst_data", frame_data_o, 32'h0);
        send(32'h0100_0001, 4);
        send(32'h4444_4444, 4);
        chk("midrst_active", 32'(active_o), 32'h0);
        chk("midrst_ignored", 32'(n_strobe - s0), 32'h0);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int          k;
            int          gap;
            logic [31:0] w;
            k = int'($urandom_range(0, 11));
            case (k)
                0:       w = SYNC;
                1, 2, 3: w = {8'h01, 8'($urandom_range(0, 18)), 16'($urandom_range(0, 3))};
                4:       w = {8'h00, 8'($urandom_range(0, 3)), 16'($urandom)};
                5:       w = 32'($urandom);
                default: w = 32'($urandom);
            endcase
            if ($urandom_range(0, 19) == 0) gap = int'($urandom_range(1, 3));
            else                            gap = int'($urandom_range(4, 7));
            send(w, gap);
            if ($urandom_range(0, 199) == 0) do_reset();
        end
        repeat (5) begin
            @(posedge clk_i); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
